// File: rtl/perf_counter_bank.sv
// Bank of NUM_EV qualified event counters plus a cycle counter, with sticky
// overflow flags, synchronous clear and an atomic shadow snapshot for readout.
module perf_counter_bank #(
  parameter  int NUM_EV = 4,
  parameter  int CNT_W  = 32,
  parameter  int SAT    = 1,
  localparam int SEL_W  = $clog2(NUM_EV + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NUM_EV-1:0]  ev_i,
  input  logic               clr_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EV:0]    ovf_o,
  output logic               snap_valid_o
);

  localparam int NCH = NUM_EV + 1;

  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_d    [NCH];
  logic [CNT_W-1:0] shadow_q [NCH];
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [NCH-1:0]   inc;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             snap_valid_q;

  // The top channel is the cycle counter; it counts whenever the qualifier is high.
  assign inc = {en_i, ev_i & {NUM_EV{en_i}}};

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SAT != 0) ? '1 : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_sel_i <= SEL_W'(NUM_EV)) rd_data_d = shadow_q[rd_sel_i];
  end

  // Shadows sample the live values from before this edge, so snap+clr keeps the pre-clear totals.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q        <= '0;
      rd_data_q    <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap_i) shadow_q[i] <= cnt_q[i];
      end
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      if (snap_i) snap_valid_q <= 1'b1;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign ovf_o        = ovf_q;
  assign snap_valid_o = snap_valid_q;

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of event counters for cache and pipeline performance statistics (I/D hit, miss, combined classes) with a qualifying enable, e.g. ~stallF.
- Adds configurable channel count and width, saturate/wrap mode, sticky overflow flags, synchronous clear, and an atomic snapshot with registered readout.
- Sits beside the pipeline and caches as a passive observer; it never stalls or back-pressures anything.

Parameters:
NUM_EV, 4, number of event channels (1..32)
CNT_W, 32, width of every counter (8..64)
SAT, 1, 1 = saturate at all-ones, 0 = wrap to zero
SEL_W, $clog2(NUM_EV+1), read-select width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  global count qualifier; no event or cycle counts while low
ev  input  NUM_EV  per-channel event strobes, one count per cycle per set bit
clr  input  1  synchronous clear of live counters and overflow flags
snap  input  1  copy all live counters into shadow registers
rd_sel  input  SEL_W  shadow index: 0..NUM_EV-1 selects event channels, NUM_EV selects the cycle counter
rd_data  output  CNT_W  registered shadow[rd_sel]
ovf  output  NUM_EV+1  sticky overflow flags; bit NUM_EV belongs to the cycle counter
snap_valid  output  1  high once any snap has occurred

Behaviour:
- Reset (rst=0, asynchronous):
  - All live counters, shadows, rd_data, ovf and snap_valid are forced to 0 immediately.
  - Release is sampled synchronously; the first count happens at the first rising edge with rst=1.
- Live counters:
  - cnt[i] increments on an edge where en & ev[i].
  - The cycle counter cnt[NUM_EV] increments on every edge where en=1.
  - With en=0, all live counters hold regardless of ev.
- Increment at all-ones:
  - SAT=1: the counter holds all-ones and the corresponding ovf bit sets.
  - SAT=0: the counter wraps to 0 and the corresponding ovf bit sets.
  - ovf bits stay set until clr or reset.
- clr:
  - On the edge, all live counters and ovf go to 0.
  - clr wins over simultaneous events; the events in that cycle are lost.
  - Shadows, snap_valid and rd_data are not affected.
- snap:
  - On the edge, shadow[i] takes cnt[i] as it was before that edge (this cycle's increments excluded), and snap_valid goes to 1.
  - All NUM_EV+1 shadows update on the same edge, so the snapshot is atomic.
- snap and clr in the same cycle: the shadow captures the pre-clear values and the live counters clear. This is the intended sample-and-restart idiom.
- Readout:
  - rd_data <= shadow[rd_sel] every edge, so latency is 1 cycle from rd_sel.
  - The value comes from the shadow as it was before that edge. A read issued in the snap cycle returns the old shadow; a read issued in the following cycle returns the new one.
  - rd_sel > NUM_EV gives rd_data = 0.
- Width rules:
  - All arithmetic is unsigned CNT_W.
  - No carry is exposed beyond the ovf flag.
  - Overflow is detected as the live value being all-ones while an increment is requested.
- Reset mid-operation: all state returns to zero immediately; no partial snapshot survives.
- Area: no combinational path from ev/en to any output.

Test Plan:
- Reset then count: rst low 3 cycles, release, en=1, ev=4'b0101 for 10 cycles, snap, rd_sel=0,1,2,4 -> rd_data 10, 0, 10, 10 (cycle counter), each 1 cycle after rd_sel; snap_valid=1, ovf=0.
- Enable gating: ev=4'b1111 for 8 cycles with en toggling 1,0,1,0,... -> every counter and the cycle counter read 4 after snap.
- Saturation (CNT_W=8, SAT=1): ev[0] held with en=1 for 300 cycles -> cnt[0]=255, ovf[0]=1, ovf[NUM_EV]=1, others 0.
- Wrap (CNT_W=8, SAT=0): ev[1] for 260 cycles -> shadow[1]=4 after snap, ovf[1]=1; then clr -> ovf=0 and live counters 0, shadow still 4.
- snap+clr same edge: count ev[2] 7 cycles, assert snap and clr together with ev[2]=1 -> shadow[2]=7, live cnt[2]=0 next cycle, a later snap after 3 more events gives shadow[2]=3.
- Async reset mid-count: after 50 counted cycles pull rst low between edges -> rd_data, ovf and snap_valid drop to 0 before the next edge; out-of-range rd_sel=NUM_EV+1 always returns 0.
